ebi_bus_master: RTL and testbench

EBI_BUS_MASTER -- requirements
Module: ebi_bus_master

---
 rtl/mecobo_bus_pkg.sv | 25 ++
 rtl/ebi_bus_master_if.sv | 18 +
 rtl/sync_ff.sv | 19 +
 rtl/ebi_bus_master.sv | 94 +++++++++
 tb/tb_ebi_bus_master.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mecobo_bus_pkg.sv
// Shared definitions for the EBI-to-pin-controller bus: widths, FSM encoding, register map.
package mecobo_bus_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [4:0] {
        ST_RELEASE = 5'b00001,
        ST_IDLE    = 5'b00010,
        ST_WR      = 5'b00100,
        ST_RD      = 5'b01000,
        ST_HOLD    = 5'b10000
    } ebi_state_t;

    // Pin-controller register offsets within a controller's address window
    localparam int REG_DUTY        = 1;
    localparam int REG_ANTI_DUTY   = 2;
    localparam int REG_CYCLES      = 3;
    localparam int REG_RUN_INF     = 4;
    localparam int REG_LOCAL_CMD   = 5;
    localparam int REG_SAMPLE_RATE = 6;
    localparam int REG_SAMPLE_REG  = 7;
    localparam int REG_PIN_MODE    = 8;

endpackage

// File: rtl/ebi_bus_master_if.sv
// Internal pin-controller bus: master drives address/data/strobes, slaves return OR-ed read data.
interface ebi_bus_master_if
    import mecobo_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wr;
    logic              bus_rd;
    logic [DATA_W-1:0] bus_rdata;

    modport master (output bus_addr, output bus_wdata, output bus_wr, output bus_rd,
                    input  bus_rdata);
    modport slave  (input  bus_addr, input  bus_wdata, input  bus_wr, input  bus_rd,
                    output bus_rdata);
endinterface

// File: rtl/sync_ff.sv
// Single-bit synchronizer chain of STAGES flops; latency STAGES clk, no backpressure.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= {STAGES{RESET_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/ebi_bus_master.sv
// Bridges the asynchronous EBI to the internal bus; bus strobe 3 clk after the EBI strobe
// falls (default sync), read data on ebi_data from clk 4. No backpressure: one strobe per EBI edge.
module ebi_bus_master
    import mecobo_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ebi_cs_n,
    input  logic              ebi_we_n,
    input  logic              ebi_re_n,
    input  logic [ADDR_W-1:0] ebi_addr,
    inout  wire  [DATA_W-1:0] ebi_data,
    ebi_bus_master_if.master  bus,
    output logic              err
);
    logic cs_s, we_s, re_s;
    logic wr_req, rd_req;
    logic ld_addr, ld_wdata, set_err;
    logic [DATA_W-1:0] rd_reg;
    logic [SYNC_STAGES-1:0] settle;
    ebi_state_t state_q, state_d;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (.clk(clk), .reset(reset), .d(ebi_cs_n), .q(cs_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_we (.clk(clk), .reset(reset), .d(ebi_we_n), .q(we_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_re (.clk(clk), .reset(reset), .d(ebi_re_n), .q(re_s));

    assign wr_req = !cs_s && !we_s;
    assign rd_req = !cs_s && !re_s;

    // Synchronizers reset to "released"; until they have refilled with real pin levels the
    // FSM must not leave RELEASE, or a strobe held across reset would look like a fresh one.
    always_ff @(posedge clk) begin
        if (reset) settle <= '0;
        else       settle <= {settle[SYNC_STAGES-2:0], 1'b1};
    end

    always_comb begin
        state_d     = state_q;
        bus.bus_wr  = 1'b0;
        bus.bus_rd  = 1'b0;
        ld_addr     = 1'b0;
        ld_wdata    = 1'b0;
        set_err     = 1'b0;
        unique case (state_q)
            ST_RELEASE: if (settle[SYNC_STAGES-1] && we_s && re_s) state_d = ST_IDLE;
            ST_IDLE: begin
                if (wr_req && rd_req) begin
                    set_err = 1'b1;
                    state_d = ST_RELEASE;
                end else if (wr_req) begin
                    ld_addr  = 1'b1;
                    ld_wdata = 1'b1;
                    state_d  = ST_WR;
                end else if (rd_req) begin
                    ld_addr = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                bus.bus_wr = 1'b1;
                state_d    = ST_RELEASE;
            end
            ST_RD: begin
                bus.bus_rd = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: if (re_s) state_d = ST_RELEASE;
            default: state_d = ST_RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RELEASE;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rd_reg        <= '0;
            err           <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_addr)          bus.bus_addr  <= ebi_addr;
            if (ld_wdata)         bus.bus_wdata <= ebi_data;
            if (state_q == ST_RD) rd_reg        <= bus.bus_rdata;
            if (set_err)          err           <= 1'b1;
        end
    end

    // Raw pins on purpose: the pad must turn around as soon as the host releases the strobe.
    assign ebi_data = (!ebi_cs_n && !ebi_re_n) ? rd_reg : {DATA_W{1'bz}};
endmodule

// File: tb/tb_ebi_bus_master.sv
// Randomized bench for ebi_bus_master with a transaction-level reference model.
module tb_ebi_bus_master;
    import mecobo_bus_pkg::*;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int SYNC = 2;

    typedef enum int {T_WR, T_RD, T_BOTH, T_NCS} kind_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ebi_cs_n = 1'b1, ebi_we_n = 1'b1, ebi_re_n = 1'b1;
    logic [AW-1:0] ebi_addr = '0;
    logic [DW-1:0] tb_dat = '0;
    logic          tb_drive = 1'b0;
    wire  [DW-1:0] ebi_data;
    logic          err;
    logic [DW-1:0] slave_mem [16];

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_err = 1'b0;

    ebi_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign ebi_data = tb_drive ? tb_dat : {DW{1'bz}};
    assign bus.bus_rdata = slave_mem[bus.bus_addr[3:0]];

    ebi_bus_master #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset),
        .ebi_cs_n(ebi_cs_n), .ebi_we_n(ebi_we_n), .ebi_re_n(ebi_re_n),
        .ebi_addr(ebi_addr), .ebi_data(ebi_data),
        .bus(bus), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One EBI transaction: strobe low for 'low' clk, then high for 'gap' clk.
    task automatic run_txn(input kind_t k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int low, input int gap);
        int wr_cnt = 0, rd_cnt = 0, wr_at = -1, rd_at = -1, overlap = 0;
        logic [AW-1:0] wa = '0, ra = '0;
        logic [DW-1:0] wd = '0;
        logic [DW-1:0] exp_rd = slave_mem[a[3:0]];
        logic [DW-1:0] data_seen = exp_rd;
        ebi_addr = a;
        tb_dat   = d;
        tb_drive = (k == T_WR || k == T_NCS);
        ebi_cs_n = (k == T_NCS);
        ebi_we_n = !(k == T_WR || k == T_BOTH || k == T_NCS);
        ebi_re_n = !(k == T_RD || k == T_BOTH);
        for (int i = 1; i <= low + gap; i++) begin
            @(negedge clk);
            if (bus.bus_wr) begin wr_cnt++; wr_at = i; wa = bus.bus_addr; wd = bus.bus_wdata; end
            if (bus.bus_rd) begin rd_cnt++; rd_at = i; ra = bus.bus_addr; end
            if (bus.bus_wr && bus.bus_rd) overlap++;
            if (k == T_RD && i >= SYNC + 2 && i <= low && ebi_data !== exp_rd) data_seen = ebi_data;
            if (k == T_RD && i == low + 1) check("rd_release_z", ebi_data, 32'h0);
            if (i == low) begin
                ebi_cs_n = 1'b1; ebi_we_n = 1'b1; ebi_re_n = 1'b1;
                tb_drive = 1'b1; tb_dat = '0;
            end
        end
        check("wr_count", wr_cnt, (k == T_WR) ? 1 : 0);
        check("rd_count", rd_cnt, (k == T_RD) ? 1 : 0);
        check("wr_rd_overlap", overlap, 0);
        if (k == T_WR) begin
            check("wr_latency", wr_at, SYNC + 1);
            check("wr_addr", wa, a);
            check("wr_data", wd, d);
            m_addr = a; m_wdata = d;
        end
        if (k == T_RD) begin
            check("rd_latency", rd_at, SYNC + 1);
            check("rd_addr", ra, a);
            check("rd_ebi_data", data_seen, exp_rd);
            m_addr = a;
        end
        if (k == T_BOTH) m_err = 1'b1;
        check("hold_addr", bus.bus_addr, m_addr);
        check("hold_wdata", bus.bus_wdata, m_wdata);
        check("err_flag", err, m_err);
    endtask

    task automatic random_txns(input int n);
        for (int t = 0; t < n; t++) begin
            int r = $urandom_range(0, 9);
            kind_t k = (r < 5) ? T_WR : (r < 8) ? T_RD : T_NCS;
            run_txn(k, AW'($urandom_range(0, (1 << AW) - 1)), DW'($urandom),
                    $urandom_range(6, 20), $urandom_range(2, 5));
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 16; i++) slave_mem[i] = DW'($urandom);
        slave_mem[4'(REG_SAMPLE_REG)] = 16'h0001;

        repeat (3) @(negedge clk);
        check("rst_bus_wr", bus.bus_wr, 0);
        check("rst_bus_rd", bus.bus_rd, 0);
        check("rst_bus_addr", bus.bus_addr, 0);
        check("rst_bus_wdata", bus.bus_wdata, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_txn(T_WR, 19'h00105, 16'h0004, 10, 3);
        run_txn(T_RD, 19'h00107, 16'h0000, 8, 3);
        run_txn(T_NCS, 19'h00103, 16'hBEEF, 8, 3);
        run_txn(T_WR, 19'h00101, 16'h0010, 8, 2);
        run_txn(T_WR, 19'h00102, 16'h0020, 8, 3);

        // Reset pulsed while the write strobe is held low.
        ebi_addr = 19'h00106; tb_dat = 16'h1234; tb_drive = 1'b1;
        ebi_cs_n = 1'b0; ebi_we_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_addr = '0; m_wdata = '0; m_err = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.bus_wr) cnt++;
        end
        check("rst_abort_wr", cnt, 0);
        check("rst_abort_addr", bus.bus_addr, 0);
        ebi_cs_n = 1'b1; ebi_we_n = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(T_WR, 19'h00108, 16'h5A5A, 7, 3);

        random_txns(20);

        run_txn(T_BOTH, 19'h00104, 16'h0000, 8, 3);
        random_txns(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
